// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall unit: FSM encoding and
// register-specifier constants.
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hs_state_e;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle of the hazard/stall unit: the ID/EX/MEM hazard sources
// going in, and the front-end enables plus performance counters coming out.
interface hazard_stall_unit_if #(
  parameter int REG_W = hazard_stall_unit_pkg::REG_W,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] rs_IF_ID;
  logic [REG_W-1:0] rt_IF_ID;
  logic             UsesRt_ID;
  logic             Branch_ID;
  logic             Taken_ID;
  logic             MemRead_ID_EX;
  logic             RegWrite_ID_EX;
  logic [REG_W-1:0] rd_ID_EX;
  logic             MemRead_EX_MEM;
  logic [REG_W-1:0] rd_EX_MEM;
  logic             Freeze;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             ID_EX_Bubble;
  logic             IF_ID_Flush;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  // Pipeline side: presents hazard sources, consumes stall/flush controls
  modport master (
    output rs_IF_ID, rt_IF_ID, UsesRt_ID, Branch_ID, Taken_ID,
           MemRead_ID_EX, RegWrite_ID_EX, rd_ID_EX,
           MemRead_EX_MEM, rd_EX_MEM, Freeze,
    input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
           StallCycles, FlushCount
  );

  // Hazard unit side
  modport slave (
    input  rs_IF_ID, rt_IF_ID, UsesRt_ID, Branch_ID, Taken_ID,
           MemRead_ID_EX, RegWrite_ID_EX, rd_ID_EX,
           MemRead_EX_MEM, rd_EX_MEM, Freeze,
    output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
           StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones,
// asynchronously cleared by clr_n_i.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step only when requested and not already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Count register with async clear
  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit: catches dependencies the forwarding network cannot
// cover (load-use, branch-in-ID operands) and stalls the front end, and
// flushes IF/ID on taken branches/jumps. A two-state FSM carries the
// second cycle of a load-feeding-branch stall.
module hazard_stall_unit #(
  parameter int CNT_W = 16,
  parameter int REG_W = hazard_stall_unit_pkg::REG_W
) (
  input  logic Clk,
  input  logic Rst_n,
  hazard_stall_unit_if.slave bus
);
  import hazard_stall_unit_pkg::*;

  hs_state_e  state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic [1:0] need;
  logic       m_ex, mb_ex, mb_mem;
  logic       pc_we, ifid_we, bubble, flush;

  // Source-operand matches; branches always read both rs and rt
  always_comb begin
    m_ex   = (bus.rd_ID_EX != REG_W'(REG_ZERO)) &&
             ((bus.rd_ID_EX == bus.rs_IF_ID) ||
              (bus.UsesRt_ID && (bus.rd_ID_EX == bus.rt_IF_ID)));
    mb_ex  = (bus.rd_ID_EX != REG_W'(REG_ZERO)) &&
             ((bus.rd_ID_EX == bus.rs_IF_ID) || (bus.rd_ID_EX == bus.rt_IF_ID));
    mb_mem = (bus.rd_EX_MEM != REG_W'(REG_ZERO)) &&
             ((bus.rd_EX_MEM == bus.rs_IF_ID) || (bus.rd_EX_MEM == bus.rt_IF_ID));
  end

  // Stall length demanded by the ID instruction; first matching rule wins
  always_comb begin
    need = 2'd0;
    if (bus.Branch_ID && bus.MemRead_ID_EX && mb_ex)        need = 2'd2;
    else if (bus.MemRead_ID_EX && m_ex)                     need = 2'd1;
    else if (bus.Branch_ID && bus.RegWrite_ID_EX && mb_ex)  need = 2'd1;
    else if (bus.Branch_ID && bus.MemRead_EX_MEM && mb_mem) need = 2'd1;
  end

  // Next state and Mealy outputs; reset and Freeze override the decision
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (!Rst_n) begin
      // hold the pass-through defaults while reset is asserted
    end else if (bus.Freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (need != 2'd0) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
            rem_d   = need - 2'd1;
            state_d = (need - 2'd1 != 2'd0) ? STALL : RUN;
          end else begin
            flush = bus.Taken_ID;
          end
        end
        STALL: begin
          // committed continuation: inputs (incl. Taken_ID) not looked at
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          bubble  = 1'b1;
          rem_d   = rem_q - 2'd1;
          if (rem_q <= 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // FSM state and remaining-stall register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (Clk),
    .clr_n_i(Rst_n),
    .inc_i  (bubble),
    .cnt_o  (bus.StallCycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (Clk),
    .clr_n_i(Rst_n),
    .inc_i  (flush),
    .cnt_o  (bus.FlushCount)
  );

  assign bus.PCWrite      = pc_we;
  assign bus.IF_ID_Write  = ifid_we;
  assign bus.ID_EX_Bubble = bubble;
  assign bus.IF_ID_Flush  = flush;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed pipeline scenarios plus random
// traffic, all checked against a cycle-level behavioural model.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  localparam int CNT_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  hazard_stall_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();

  hazard_stall_unit #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (hif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: stall cycles still owed after the current one, and counter values
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit reads(input int x, input bit rt_used);
    return (x != 0) && ((x == int'(hif.rs_IF_ID)) || (rt_used && x == int'(hif.rt_IF_ID)));
  endfunction

  // stall length the ID instruction needs, straight from the hazard rules
  function automatic int model_need();
    if (hif.Branch_ID && hif.MemRead_ID_EX && reads(int'(hif.rd_ID_EX), 1)) return 2;
    if (hif.MemRead_ID_EX && reads(int'(hif.rd_ID_EX), hif.UsesRt_ID))     return 1;
    if (hif.Branch_ID && hif.RegWrite_ID_EX && reads(int'(hif.rd_ID_EX), 1)) return 1;
    if (hif.Branch_ID && hif.MemRead_EX_MEM && reads(int'(hif.rd_EX_MEM), 1)) return 1;
    return 0;
  endfunction

  task automatic drive(input int rs, input int rt, input bit uses, input bit br, input bit tk,
                       input bit mr_ex, input bit rw_ex, input int rd_ex,
                       input bit mr_mem, input int rd_mem, input bit frz);
    hif.rs_IF_ID       = REG_W'(rs);
    hif.rt_IF_ID       = REG_W'(rt);
    hif.UsesRt_ID      = uses;
    hif.Branch_ID      = br;
    hif.Taken_ID       = tk;
    hif.MemRead_ID_EX  = mr_ex;
    hif.RegWrite_ID_EX = rw_ex;
    hif.rd_ID_EX       = REG_W'(rd_ex);
    hif.MemRead_EX_MEM = mr_mem;
    hif.rd_EX_MEM      = REG_W'(rd_mem);
    hif.Freeze         = frz;
  endtask

  // inputs are driven at the falling edge; check, take one rising edge,
  // advance the model, and return at the next falling edge
  task automatic step(input string tag);
    int  n;
    bit  e_pc, e_ifid, e_bub, e_fl, tk;
    n = model_need();
    tk = hif.Taken_ID;
    if (hif.Freeze)          {e_pc, e_ifid, e_bub, e_fl} = 4'b0000;
    else if (m_left > 0)     {e_pc, e_ifid, e_bub, e_fl} = 4'b0010;
    else if (n > 0)          {e_pc, e_ifid, e_bub, e_fl} = 4'b0010;
    else                     {e_pc, e_ifid, e_bub, e_fl} = {3'b110, tk};
    #1;
    chk({tag, ".pc"},    hif.PCWrite,      e_pc);
    chk({tag, ".ifid"},  hif.IF_ID_Write,  e_ifid);
    chk({tag, ".bub"},   hif.ID_EX_Bubble, e_bub);
    chk({tag, ".flush"}, hif.IF_ID_Flush,  e_fl);
    chk({tag, ".scnt"},  hif.StallCycles,  m_stall);
    chk({tag, ".fcnt"},  hif.FlushCount,   m_flush);
    @(posedge Clk);
    if (!hif.Freeze) begin
      if (m_left > 0) begin
        m_left--;
        if (m_stall < MAXC) m_stall++;
      end else if (n > 0) begin
        m_left = n - 1;
        if (m_stall < MAXC) m_stall++;
      end else if (tk) begin
        if (m_flush < MAXC) m_flush++;
      end
    end
    @(negedge Clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    #2;
    m_left = 0; m_stall = 0; m_flush = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    // reset: pending load-use hazard must not leak through while in reset
    drive(2, 4, 1, 0, 1, 1, 1, 2, 0, 0, 0);
    #1;
    chk("rst.pc",   hif.PCWrite,      1'b1);
    chk("rst.ifid", hif.IF_ID_Write,  1'b1);
    chk("rst.bub",  hif.ID_EX_Bubble, 1'b0);
    chk("rst.fl",   hif.IF_ID_Flush,  1'b0);
    chk("rst.scnt", hif.StallCycles,  0);
    chk("rst.fcnt", hif.FlushCount,   0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // lw $2 in EX, add $3,$2,$4 in ID: single bubble
    drive(2, 4, 1, 0, 0, 1, 1, 2, 0, 0, 0);  step("lu");
    idle();                                   step("lu_after");
    chk("lu.scnt_is_1", hif.StallCycles, 1);

    // no stall: destination $0, or rt match that isn't read
    drive(0, 4, 1, 0, 0, 1, 1, 0, 0, 0, 0);  step("lu_r0");
    drive(1, 4, 0, 0, 0, 1, 1, 4, 0, 0, 0);  step("lu_nort");

    // beq $5,$6 with lw $6 in EX: two bubbles, then taken flush
    do_reset();
    drive(5, 6, 1, 1, 1, 1, 1, 6, 0, 0, 0);  step("bl0");
    drive(5, 6, 1, 1, 1, 0, 0, 0, 1, 6, 0);  step("bl1");
    drive(5, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0);  step("bl_flush");
    idle();                                   step("bl_done");
    chk("bl.scnt_is_2", hif.StallCycles, 2);
    chk("bl.fcnt_is_1", hif.FlushCount, 1);

    // beq on add $7 in EX, taken held: flush waits for the next RUN cycle
    drive(7, 8, 1, 1, 1, 0, 1, 7, 0, 0, 0);  step("ba_stall");
    drive(7, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0);  step("ba_flush");
    idle();                                   step("ba_done");

    // freeze for 3 cycles in the middle of a two-cycle stall
    drive(5, 6, 1, 1, 0, 1, 1, 6, 0, 0, 0);  step("fz_enter");
    for (int i = 0; i < 3; i++) begin
      drive(5, 6, 1, 1, 0, 0, 0, 0, 1, 6, 1); step("fz_hold");
    end
    drive(5, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0);  step("fz_resume");
    idle();                                   step("fz_done");

    // async reset between edges while in STALL
    drive(5, 6, 1, 1, 1, 1, 1, 6, 0, 0, 0);  step("ar_enter");
    #2;
    Rst_n = 1'b0;
    #1;
    chk("ar.pc",   hif.PCWrite,      1'b1);
    chk("ar.bub",  hif.ID_EX_Bubble, 1'b0);
    chk("ar.scnt", hif.StallCycles,  0);
    chk("ar.fcnt", hif.FlushCount,   0);
    m_left = 0; m_stall = 0; m_flush = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    idle();                                   step("ar_run");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
            ($urandom_range(0, 2) == 0), 1'($urandom),
            ($urandom_range(0, 2) == 0), 1'($urandom), $urandom_range(0, 3),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0));
      step("rnd");
    end

    // saturation: hold a load-use hazard for 2^16+5 cycles
    do_reset();
    drive(2, 4, 1, 0, 0, 1, 1, 2, 0, 0, 0);
    repeat ((1 << CNT_W) + 5) @(posedge Clk);
    @(negedge Clk);
    m_stall = MAXC;
    m_left  = 0;
    chk("sat.scnt", hif.StallCycles, 16'hFFFF);
    step("sat_hold0");
    step("sat_hold1");
    chk("sat.scnt_held", hif.StallCycles, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard stop in case something upstream hangs
  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Companion to the forwarding logic: detects the hazards that bypassing cannot resolve and stalls or flushes the front end instead.
- Covers load-use and branch-in-ID operand dependencies, plus taken branches and jumps.
- Sits beside the IF/ID and ID/EX pipeline registers. It drives PC write-enable, IF/ID write-enable, the ID/EX control-bubble mux and the IF/ID flush.
- Holds a small FSM for multi-cycle stalls and saturating performance counters.

Parameters:
CNT_W, 16, width of StallCycles and FlushCount counters
REG_W, 5, register-specifier width

Ports:
Clk  in  1  pipeline clock, rising edge
Rst_n  in  1  asynchronous active-low reset
rs_IF_ID  in  REG_W  Instruction[25:21] of instruction in ID
rt_IF_ID  in  REG_W  Instruction[20:16] of instruction in ID
UsesRt_ID  in  1  ID instruction reads rt as a source (R-type, beq/bne, sw)
Branch_ID  in  1  ID instruction is beq/bne (compare done in ID)
Taken_ID  in  1  ID branch compare true, or jump in ID
MemRead_ID_EX  in  1  EX-stage instruction is a load
RegWrite_ID_EX  in  1  EX-stage instruction writes a register
rd_ID_EX  in  REG_W  EX-stage destination (rt for load/I-type, rd for R-type)
MemRead_EX_MEM  in  1  MEM-stage instruction is a load
rd_EX_MEM  in  REG_W  MEM-stage destination
Freeze  in  1  external hold (multi-cycle memory); freezes everything
PCWrite  out  1  PC register enable
IF_ID_Write  out  1  IF/ID register enable
ID_EX_Bubble  out  1  zero control fields into ID/EX
IF_ID_Flush  out  1  clear IF/ID to nop
StallCycles  out  CNT_W  saturating count of hazard-stall cycles
FlushCount  out  CNT_W  saturating count of flushes

Behaviour:
- Source match definitions:
  - match(x) = (x != 0) && ((x == rs_IF_ID) || (UsesRt_ID && x == rt_IF_ID)).
  - Branch rules use the same match, with UsesRt_ID assumed 1 for branches.
- need, evaluated combinationally in RUN, with the first true rule winning:
  - need = 2 if Branch_ID && MemRead_ID_EX && match(rd_ID_EX)
  - need = 1 if MemRead_ID_EX && match(rd_ID_EX) (load-use)
  - need = 1 if Branch_ID && RegWrite_ID_EX && match(rd_ID_EX)
  - need = 1 if Branch_ID && MemRead_EX_MEM && match(rd_EX_MEM)
  - need = 0 otherwise
- FSM states: RUN, STALL. A 2-bit remaining counter rem is used.
- RUN, need > 0 (stall cycle):
  - Same cycle (Mealy): PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
  - Next edge: rem <= need-1; go to STALL if need-1 > 0, else stay in RUN.
- RUN, need = 0:
  - PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0.
  - IF_ID_Flush = Taken_ID.
- STALL:
  - Stall outputs asserted unconditionally; inputs are not re-evaluated.
  - Each edge rem decrements; return to RUN when rem reaches 0.
  - Taken_ID is ignored while stalled; the branch is re-evaluated on the first RUN cycle after the stall.
- Priority: a stall beats a flush. Flush is asserted only in a non-stall RUN cycle.
- Freeze=1:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0.
  - State, rem and counters hold.
  - Hazard decisions resume unchanged when Freeze drops.
- Counters:
  - StallCycles += 1 on each edge where ID_EX_Bubble=1.
  - FlushCount += 1 on each edge where IF_ID_Flush=1.
  - Both saturate at all-ones; no wrap.
- Reset (Rst_n=0, asynchronous, any time including mid-stall):
  - state=RUN, rem=0, counters=0.
  - Outputs while in reset: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0.
- Latency: decisions are same-cycle combinational; only multi-cycle continuation and the counters are registered.

Decomposition:
- Shared pipeline package holds:
  - state encoding (RUN=1'b0, STALL=1'b1)
  - REG_W
  - constant REG_ZERO=5'd0
- One natural sub-module: sat_counter (parameterised CNT_W, inc input, synchronous saturate, async active-low clear). It is instantiated twice.

Test Plan:
- lw $2,0($1) in EX; add $3,$2,$4 in ID (rs_IF_ID=2, rd_ID_EX=2, MemRead_ID_EX=1) -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, then RUN; StallCycles=1.
- Same as above but rd_ID_EX=0, or rt match with UsesRt_ID=0 -> no stall; all enables 1.
- beq $5,$6 in ID, lw writing $6 in EX -> exactly two stall cycles (state RUN->STALL->RUN), rem 1->0; StallCycles=2. Then Taken_ID=1 -> IF_ID_Flush=1 for one cycle; FlushCount=1.
- beq depends on add ($7) in EX, RegWrite_ID_EX=1 -> one stall. Taken_ID=1 held during the stall -> no flush until the following RUN cycle.
- Assert Freeze during a STALL cycle for 3 cycles -> all outputs 0 except PCWrite/IF_ID_Write also 0; rem and counters unchanged; the stall finishes after Freeze drops.
- Drive Rst_n low mid-STALL (asynchronous, between edges) -> immediately PCWrite=1, Bubble=0, counters=0, state RUN.
- Force 2^16+5 bubble cycles -> StallCycles=16'hFFFF, held there.
